// File: rtl/light_phase_sequencer_pkg.sv
// light_seq_pkg: phase states, lamp encodings and mode bit indices shared by the light sequencer
package light_seq_pkg;
  typedef enum logic [2:0] {NS_GREEN, NS_YELLOW, ALLRED_A, EW_GREEN, EW_YELLOW, ALLRED_B, WALK, EMERG} state_t;
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;
  localparam int MODE_EMERG = 3;
  localparam int MODE_PED = 2;
  localparam int MODE_NIGHT = 1;
  localparam int MODE_DAY = 0;
  function automatic logic [2:0] lamp(state_t s, logic ns);
    return ns ? (s == NS_GREEN ? LAMP_G : s == NS_YELLOW ? LAMP_Y : LAMP_R)
              : (s == EW_GREEN ? LAMP_G : s == EW_YELLOW ? LAMP_Y : LAMP_R);
  endfunction
endpackage

// File: rtl/light_phase_sequencer_if.sv
// light_phase_sequencer_if: mode handshake and lamp outputs between mode arbiter and sequencer
interface light_phase_sequencer_if #(parameter int TIMER_W = 8);
  logic [3:0] mode_onehot;
  logic mode_valid;
  logic mode_ready;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic walk;
  logic [TIMER_W-1:0] timer_out;
  logic err_onehot;
  modport master (output mode_onehot, mode_valid, input mode_ready, ns_light, ew_light, walk, timer_out, err_onehot);
  modport slave (input mode_onehot, mode_valid, output mode_ready, ns_light, ew_light, walk, timer_out, err_onehot);
endinterface

// File: rtl/light_phase_sequencer_phase_timer.sv
// phase_timer: loadable down-counter that holds at zero and flags it
module phase_timer #(
  parameter int W = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic zero
);
  logic [W-1:0] cnt_q, cnt_d;
  assign zero = cnt_q == '0;
  assign count = cnt_q;
  always_comb cnt_d = load ? load_val : zero ? cnt_q : cnt_q - W'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= RST_VAL;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/light_phase_sequencer.sv
// light_phase_sequencer: intersection phase FSM with boundary mode handshake and emergency pre-emption; LIGHT_SEQ_ONEHOT_CHECK_EN rejects non-one-hot words
module light_phase_sequencer
  import light_seq_pkg::*;
#(
  parameter int TIMER_W = 8,
  parameter int GREEN_DAY = 30,
  parameter int GREEN_NIGHT = 15,
  parameter int YELLOW_T = 4,
  parameter int ALLRED_T = 2,
  parameter int WALK_T = 10,
  parameter int EMERG_T = 20
) (
  input logic clk,
  input logic rst,
  light_phase_sequencer_if.slave bus
);
  localparam logic [TIMER_W-1:0] T_GD = TIMER_W'(GREEN_DAY - 1);
  localparam logic [TIMER_W-1:0] T_GN = TIMER_W'(GREEN_NIGHT - 1);
  localparam logic [TIMER_W-1:0] T_Y = TIMER_W'(YELLOW_T - 1);
  localparam logic [TIMER_W-1:0] T_AR = TIMER_W'(ALLRED_T - 1);
  localparam logic [TIMER_W-1:0] T_W = TIMER_W'(WALK_T - 1);
  localparam logic [TIMER_W-1:0] T_E = TIMER_W'(EMERG_T - 1);
  state_t state_q, state_d;
  logic night_q, night_d, next_ew_q, next_ew_d, pend_q, pend_d;
  logic err_q, err_d, walk_q, walk_d;
  logic [2:0] ns_q, ns_d, ew_q, ew_d;
  logic [TIMER_W-1:0] load_val, tmr;
  logic zero, load, in_green, boundary, xfer, pre_xfer, legal;
  logic [3:0] w;
  assign in_green = state_q == NS_GREEN || state_q == EW_GREEN;
  assign boundary = (state_q == ALLRED_A || state_q == ALLRED_B) && zero && !pend_q;
  assign bus.mode_ready = !rst && (boundary || (in_green && bus.mode_onehot == 4'b1000));
  assign xfer = bus.mode_valid && bus.mode_ready;
  assign pre_xfer = xfer && in_green;
  assign load = zero || pre_xfer;
`ifdef LIGHT_SEQ_ONEHOT_CHECK_EN
  assign legal = $onehot(bus.mode_onehot);
  assign w = legal ? bus.mode_onehot : 4'b0000;
`else
  assign legal = 1'b1;
  assign w = bus.mode_onehot;
`endif
  always_comb begin
    state_d = state_q;
    night_d = night_q;
    next_ew_d = next_ew_q;
    pend_d = pend_q;
    if (pre_xfer) begin
      state_d = state_q == NS_GREEN ? NS_YELLOW : EW_YELLOW;
      pend_d = 1'b1;
    end else if (zero) begin
      case (state_q)
        NS_GREEN: state_d = NS_YELLOW;
        NS_YELLOW: begin
          state_d = ALLRED_A;
          next_ew_d = 1'b1;
        end
        EW_GREEN: state_d = EW_YELLOW;
        EW_YELLOW: begin
          state_d = ALLRED_B;
          next_ew_d = 1'b0;
        end
        ALLRED_A, ALLRED_B: begin
          if (pend_q || (xfer && w[MODE_EMERG])) state_d = EMERG;
          else if (xfer && w[MODE_PED]) state_d = WALK;
          else state_d = next_ew_q ? EW_GREEN : NS_GREEN;
          // night outranks day when both are set; pedestrian/emergency leave the latch alone
          if (xfer && w[3:2] == 2'b00 && (w[MODE_NIGHT] || w[MODE_DAY])) night_d = w[MODE_NIGHT];
          pend_d = 1'b0;
        end
        default: state_d = next_ew_q ? EW_GREEN : NS_GREEN;
      endcase
    end
    case (state_d)
      NS_GREEN, EW_GREEN: load_val = night_d ? T_GN : T_GD;
      NS_YELLOW, EW_YELLOW: load_val = T_Y;
      ALLRED_A, ALLRED_B: load_val = T_AR;
      WALK: load_val = T_W;
      default: load_val = T_E;
    endcase
    ns_d = lamp(state_d, 1'b1);
    ew_d = lamp(state_d, 1'b0);
    walk_d = state_d == WALK;
    err_d = xfer && !legal;
  end
  phase_timer #(.W(TIMER_W), .RST_VAL(T_AR)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(load),
    .load_val(load_val),
    .count(tmr),
    .zero(zero)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ALLRED_B;
      night_q <= 1'b0;
      next_ew_q <= 1'b0;
      pend_q <= 1'b0;
      err_q <= 1'b0;
      walk_q <= 1'b0;
      ns_q <= LAMP_R;
      ew_q <= LAMP_R;
    end else begin
      state_q <= state_d;
      night_q <= night_d;
      next_ew_q <= next_ew_d;
      pend_q <= pend_d;
      err_q <= err_d;
      walk_q <= walk_d;
      ns_q <= ns_d;
      ew_q <= ew_d;
    end
  assign bus.ns_light = ns_q;
  assign bus.ew_light = ew_q;
  assign bus.walk = walk_q;
  assign bus.timer_out = tmr;
  assign bus.err_onehot = err_q;
endmodule

// File: tb/tb_light_phase_sequencer.sv
// tb_light_phase_sequencer: scoreboarded random and directed stimulus against a phase-schedule reference model
module tb_light_phase_sequencer;
  localparam int GD = 30, GN = 15, YT = 4, AT = 2, WT = 10, ET = 20;
  localparam int P_NSG = 0, P_NSY = 1, P_ARA = 2, P_EWG = 3, P_EWY = 4, P_ARB = 5, P_WALK = 6, P_EMG = 7;
  typedef struct {
    bit rdy;
    bit [2:0] ns;
    bit [2:0] ew;
    bit wk;
    int tmr;
    bit err;
  } exp_t;
  logic clk = 0;
  logic rst;
  int total = 0, bad = 0;
  int ph, rem;
  bit night, to_ew, pend, err_exp;
  exp_t sb[$];
  exp_t cur;
  light_phase_sequencer_if #(.TIMER_W(8)) bus();
  light_phase_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, req, $time);
    end
  endtask
  function automatic bit [2:0] lamp_of(input int p, input bit ns);
    if (p == (ns ? P_NSG : P_EWG)) return 3'b001;
    if (p == (ns ? P_NSY : P_EWY)) return 3'b010;
    return 3'b100;
  endfunction
  function automatic int dur(input int p);
    case (p)
      P_NSG, P_EWG: return night ? GN : GD;
      P_NSY, P_EWY: return YT;
      P_ARA, P_ARB: return AT;
      P_WALK: return WT;
      default: return ET;
    endcase
  endfunction
  // 4 emergency, 3 pedestrian, 2 night, 1 day, 0 nothing
  function automatic int decode(input logic [3:0] w, output bit illegal);
    illegal = 0;
`ifdef LIGHT_SEQ_ONEHOT_CHECK_EN
    illegal = $countones(w) != 1;
    if (illegal) return 0;
`endif
    for (int b = 3; b >= 0; b--) if (w[b]) return b + 1;
    return 0;
  endfunction
  function automatic bit exp_ready(input logic [3:0] w);
    return ((ph == P_ARA || ph == P_ARB) && rem == 1 && !pend) || ((ph == P_NSG || ph == P_EWG) && w == 4'b1000);
  endfunction
  task automatic enter(input int p);
    ph = p;
    rem = dur(p);
  endtask
  task automatic model_reset();
    night = 0; to_ew = 0; pend = 0; err_exp = 0;
    ph = P_ARB; rem = AT;
  endtask
  task automatic advance(input bit v, input logic [3:0] w);
    bit xf, illegal;
    int k;
    xf = v && exp_ready(w);
    k = decode(w, illegal);
    err_exp = xf && illegal;
    if (xf && (ph == P_NSG || ph == P_EWG)) begin
      pend = 1;
      enter(ph == P_NSG ? P_NSY : P_EWY);
      return;
    end
    rem--;
    if (rem > 0) return;
    case (ph)
      P_NSG: enter(P_NSY);
      P_NSY: begin to_ew = 1; enter(P_ARA); end
      P_EWG: enter(P_EWY);
      P_EWY: begin to_ew = 0; enter(P_ARB); end
      P_ARA, P_ARB: begin
        if (!xf) k = 0;
        if (pend) begin pend = 0; enter(P_EMG); end
        else if (k == 4) enter(P_EMG);
        else if (k == 3) enter(P_WALK);
        else begin
          if (k == 2) night = 1;
          if (k == 1) night = 0;
          enter(to_ew ? P_EWG : P_NSG);
        end
      end
      default: enter(to_ew ? P_EWG : P_NSG);
    endcase
  endtask
  task automatic step(input bit v, input logic [3:0] w);
    exp_t e;
    @(negedge clk);
    bus.mode_valid = v;
    bus.mode_onehot = w;
    #1;
    e.rdy = exp_ready(w);
    e.ns = lamp_of(ph, 1);
    e.ew = lamp_of(ph, 0);
    e.wk = ph == P_WALK;
    e.tmr = rem - 1;
    e.err = err_exp;
    sb.push_back(e);
    advance(v, w);
  endtask
  task automatic wait_for(input int p, input int r);
    int n = 0;
    while (!(ph == p && rem == r)) begin
      if (n++ > 400) begin
        chk("wait_phase", ph, p);
        return;
      end
      step(0, 4'b0000);
    end
  endtask
  task automatic rand_steps(input int n);
    logic [3:0] tbl[7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0110, 4'b0000, 4'b0011};
    int pick;
    logic [3:0] w;
    for (int i = 0; i < n; i++) begin
      pick = $urandom_range(0, 7);
      w = pick == 7 ? 4'($urandom) : tbl[pick];
      step($urandom_range(0, 3) == 0, w);
    end
  endtask
  task automatic check_reset();
    chk("rst_ns", bus.ns_light, 3'b100);
    chk("rst_ew", bus.ew_light, 3'b100);
    chk("rst_walk", bus.walk, 0);
    chk("rst_ready", bus.mode_ready, 0);
    chk("rst_timer", bus.timer_out, AT - 1);
    chk("rst_err", bus.err_onehot, 0);
  endtask
  initial forever begin
    @(negedge clk);
    #2;
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      chk("ready", bus.mode_ready, cur.rdy);
      chk("ns_light", bus.ns_light, cur.ns);
      chk("ew_light", bus.ew_light, cur.ew);
      chk("walk", bus.walk, cur.wk);
      chk("timer", bus.timer_out, cur.tmr);
      chk("err", bus.err_onehot, cur.err);
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time bound");
    $fatal(1);
  end
  initial begin
    rst = 1;
    bus.mode_valid = 0;
    bus.mode_onehot = 0;
    model_reset();
    #3;
    check_reset();
    repeat (2) @(posedge clk);
    #2;
    rst = 0;
    repeat (70) step(0, 4'b0000);
    wait_for(P_ARA, 1);
    step(1, 4'b0010);
    wait_for(P_ARB, 1);
    step(1, 4'b0100);
    wait_for(P_NSG, GN - 5);
    step(1, 4'b1000);
    wait_for(P_ARB, 1);
    step(1, 4'b0110);
    wait_for(P_ARA, 1);
    step(1, 4'b0001);
    repeat (40) step(0, 4'b0000);
    rand_steps(3000);
    wait_for(P_EWG, 10);
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    check_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst = 0;
    repeat (80) step(0, 4'b0000);
    rand_steps(1000);
    @(negedge clk);
    #3;
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
